// File: rtl/proc_control_fsm.sv
// proc_control_fsm
// ----------------
// Sequencing controller for the multi-cycle processor datapath. It fetches a
// 9-bit instruction word IIIXXXYYY into the IR in T0. It then steps through
// T1..T3 and drives the bus-source selects and the register load enables for
// each timestep.
//
// Optional feature: define PROC_CTRL_MVNZ_EN to make opcode 100 execute
// "mvnz Rx,Ry". In the default build opcode 100 is illegal and g_zero is
// unused.
//
// Ports:
//   clock   - single clock, rising edge active
//   reset   - synchronous, active-high; returns to T0 with IR cleared
//   run     - start request, sampled only in T0
//   din     - instruction word (T0); immediate data for mvi (T1)
//   g_zero  - G register is all zeros (used only by mvnz)
//   ir      - current instruction register (debug)
//   ir_in   - IR load strobe
//   rout    - one-hot bus select, bit n = Rn
//   gout    - bus source is G
//   dinout  - bus source is DIN
//   rin     - one-hot register load enables
//   ain     - A register load enable
//   gin     - G register load enable
//   addsub  - ALU op: 0 add, 1 subtract (meaningful in T2 only)
//   done    - one-cycle pulse in the final step of an instruction

module proc_control_fsm #(
    parameter int DW = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic [DW-1:0] din,
    input  logic          g_zero,
    output logic [DW-1:0] ir,
    output logic          ir_in,
    output logic [7:0]    rout,
    output logic          gout,
    output logic          dinout,
    output logic [7:0]    rin,
    output logic          ain,
    output logic          gin,
    output logic          addsub,
    output logic          done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t state;
    step_t next_state;

    logic [2:0] opcode;
    logic [7:0] x_sel;
    logic [7:0] y_sel;

    // Field decode of the latched instruction, with X and Y expanded to
    // one-hot register selects.
    assign opcode = ir[8:6];
    assign x_sel  = 8'd1 << ir[5:3];
    assign y_sel  = 8'd1 << ir[2:0];

`ifndef PROC_CTRL_MVNZ_EN
    // Without mvnz nothing looks at the G-zero flag.
    logic unused_g_zero;
    assign unused_g_zero = g_zero;
`endif

    // Step register and IR. The IR only loads on a T0 fetch strobe, and a
    // reset always lands in T0 with a cleared IR.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (ir_in) begin
                ir <= din;
            end
        end
    end

    // Next-step and output decode. Each step asserts only what it needs, so
    // at most one bus source is ever selected. While reset is high, all
    // outputs are forced low. This keeps an aborted instruction from firing
    // its remaining enables in the reset cycle.
    always_comb begin
        next_state = state;
        ir_in      = 1'b0;
        rout       = 8'h00;
        gout       = 1'b0;
        dinout     = 1'b0;
        rin        = 8'h00;
        ain        = 1'b0;
        gin        = 1'b0;
        addsub     = 1'b0;
        done       = 1'b0;

        unique case (state)
            T0: begin
                ir_in = run;
                if (run) begin
                    next_state = T1;
                end
            end

            T1: begin
                next_state = T0;
                unique case (opcode)
                    3'b000: begin
                        rout = y_sel;
                        rin  = x_sel;
                        done = 1'b1;
                    end
                    3'b001: begin
                        dinout = 1'b1;
                        rin    = x_sel;
                        done   = 1'b1;
                    end
                    3'b010, 3'b011: begin
                        rout       = x_sel;
                        ain        = 1'b1;
                        next_state = T2;
                    end
`ifdef PROC_CTRL_MVNZ_EN
                    3'b100: begin
                        if (!g_zero) begin
                            rout = y_sel;
                            rin  = x_sel;
                        end
                        done = 1'b1;
                    end
`endif
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end

            T2: begin
                rout       = y_sel;
                gin        = 1'b1;
                addsub     = opcode[0];
                next_state = T3;
            end

            T3: begin
                gout       = 1'b1;
                rin        = x_sel;
                done       = 1'b1;
                next_state = T0;
            end

            default: begin
                next_state = T0;
            end
        endcase

        if (reset) begin
            ir_in  = 1'b0;
            rout   = 8'h00;
            gout   = 1'b0;
            dinout = 1'b0;
            rin    = 8'h00;
            ain    = 1'b0;
            gin    = 1'b0;
            addsub = 1'b0;
            done   = 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Testbench for proc_control_fsm: directed instruction sequences with
// hand-computed output vectors, followed by a random back-to-back stream
// that is checked against a small step model and the one-hot invariants.
module tb_proc_control_fsm;

    logic       clock;
    logic       reset;
    logic       run;
    logic [8:0] din;
    logic       g_zero;
    logic [8:0] ir;
    logic       ir_in;
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;

    int compared;
    int mismatched;

    proc_control_fsm #(.DW(9)) dut (
        .clock  (clock),
        .reset  (reset),
        .run    (run),
        .din    (din),
        .g_zero (g_zero),
        .ir     (ir),
        .ir_in  (ir_in),
        .rout   (rout),
        .gout   (gout),
        .dinout (dinout),
        .rin    (rin),
        .ain    (ain),
        .gin    (gin),
        .addsub (addsub),
        .done   (done)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Packs all control outputs into one word:
    // {ir_in, rout, gout, dinout, rin, ain, gin, addsub, done}.
    function automatic logic [31:0] ev(input logic e_ir_in, input logic [7:0] e_rout,
                                       input logic e_gout, input logic e_dinout,
                                       input logic [7:0] e_rin, input logic e_ain,
                                       input logic e_gin, input logic e_addsub,
                                       input logic e_done);
        return {9'd0, e_ir_in, e_rout, e_gout, e_dinout, e_rin, e_ain, e_gin, e_addsub, e_done};
    endfunction

    function automatic logic [31:0] obs();
        return ev(ir_in, rout, gout, dinout, rin, ain, gin, addsub, done);
    endfunction

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits for the next rising edge, drives the inputs just after it, and
    // lets the combinational outputs settle before returning.
    task automatic applyStimulus(input logic s_reset, input logic s_run,
                                 input logic [8:0] s_din, input logic s_gz);
        @(posedge clock);
        #1;
        reset  = s_reset;
        run    = s_run;
        din    = s_din;
        g_zero = s_gz;
        #1;
    endtask

    logic [31:0] zero_vec;
    logic [31:0] fetch_vec;
    int          done_count;
    int          stream_done;
    int          stream_fetch;
    int          model_step;
    logic [2:0]  model_op;
    int          pop_src;
    int          pop_rin;

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        run        = 1'b0;
        din        = 9'd0;
        g_zero     = 1'b0;
        zero_vec   = ev(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch_vec  = ev(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);

        // Idle after reset: everything low, IR cleared.
        applyStimulus(1'b0, 1'b0, 9'h1FF, 1'b0);
        checkOutput("reset_outputs", obs(), zero_vec);
        checkOutput("reset_ir", {23'd0, ir}, 32'h0);

        // mvi R3,#D
        applyStimulus(1'b0, 1'b1, 9'b001_011_000, 1'b0);
        checkOutput("mvi_t0", obs(), fetch_vec);
        applyStimulus(1'b0, 1'b0, 9'h055, 1'b0);
        checkOutput("mvi_t1", obs(), ev(1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1));
        checkOutput("mvi_ir", {23'd0, ir}, 32'h058);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("mvi_back_t0", obs(), zero_vec);

        // add R1,R2
        applyStimulus(1'b0, 1'b1, 9'b010_001_010, 1'b0);
        checkOutput("add_t0", obs(), fetch_vec);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("add_t1", obs(), ev(1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("add_t2", obs(), ev(1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("add_t3", obs(), ev(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("add_back_t0", obs(), zero_vec);

        // sub R0,R7: run is held high in T1..T3, where it must be ignored.
        done_count = 0;
        applyStimulus(1'b0, 1'b1, 9'b011_000_111, 1'b0);
        checkOutput("sub_t0", obs(), fetch_vec);
        applyStimulus(1'b0, 1'b1, 9'b001_000_000, 1'b0);
        checkOutput("sub_t1", obs(), ev(1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        done_count += int'(done);
        applyStimulus(1'b0, 1'b1, 9'b001_000_000, 1'b0);
        checkOutput("sub_t2", obs(), ev(1'b0, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
        done_count += int'(done);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("sub_t3", obs(), ev(1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1));
        done_count += int'(done);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        done_count += int'(done);
        checkOutput("sub_back_t0", obs(), zero_vec);
        checkOutput("sub_done_pulses", done_count, 32'd1);

        // Reset during T2 of an add: no gin/gout/rin from the aborted op.
        applyStimulus(1'b0, 1'b1, 9'b010_001_010, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        applyStimulus(1'b1, 1'b0, 9'h000, 1'b0);
        checkOutput("abort_reset_cycle", obs(), zero_vec);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("abort_next", obs(), zero_vec);
        checkOutput("abort_ir", {23'd0, ir}, 32'h0);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("abort_idle", obs(), zero_vec);

        // mv R5,R3
        applyStimulus(1'b0, 1'b1, 9'b000_101_011, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("mv_t1", obs(), ev(1'b0, 8'h08, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1));

        // Opcode 100 (X=2, Y=6) with g_zero low, then high.
        applyStimulus(1'b0, 1'b1, 9'b100_010_110, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
`ifdef PROC_CTRL_MVNZ_EN
        checkOutput("op100_gz0", obs(), ev(1'b0, 8'h40, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1));
`else
        checkOutput("op100_gz0", obs(), ev(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
`endif
        applyStimulus(1'b0, 1'b1, 9'b100_010_110, 1'b1);
        checkOutput("op100_refetch", obs(), fetch_vec);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
        checkOutput("op100_gz1", obs(), ev(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));

        // Illegal opcode 111: done only, then back to T0.
        applyStimulus(1'b0, 1'b1, 9'b111_001_001, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("illegal_t1", obs(), ev(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0);
        checkOutput("illegal_back_t0", obs(), zero_vec);

        // Random back-to-back stream with run held high, tracked by a step
        // model. Every cycle, the fetch strobe and done must match the model,
        // and both one-hot invariants must hold.
        stream_done  = 0;
        stream_fetch = 0;
        model_step   = 0;
        model_op     = 3'b000;
        for (int cyc = 0; cyc < 3000 && stream_done < 200; cyc++) begin
            applyStimulus(1'b0, 1'b1, 9'($urandom), 1'($urandom));
            pop_src = $countones(rout) + int'(gout) + int'(dinout);
            pop_rin = $countones(rin);
            checkOutput("stream_bus_onehot", 32'(pop_src <= 1), 32'd1);
            checkOutput("stream_rin_onehot", 32'(pop_rin <= 1), 32'd1);
            checkOutput("stream_ir_in", {31'd0, ir_in}, 32'(model_step == 0));
            checkOutput("stream_done",  {31'd0, done},
                        32'((model_step == 1 && model_op[2:1] != 2'b01) || model_step == 3));
            stream_done  += int'(done);
            stream_fetch += int'(ir_in);
            case (model_step)
                0:       begin model_op = din[8:6]; model_step = 1; end
                1:       model_step = (model_op[2:1] == 2'b01) ? 2 : 0;
                2:       model_step = 3;
                default: model_step = 0;
            endcase
        end
        checkOutput("stream_done_total", stream_done, 32'd200);
        checkOutput("stream_fetch_total", stream_fetch, 32'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/proc_control_fsm.md
# proc_control_fsm

Sequencing controller for the multi-cycle processor datapath. It latches a 9-bit instruction word `IIIXXXYYY`, decodes it, and steps through timesteps T0–T3. In each timestep it drives the one-hot bus-source selects (`rout`, `gout`, `dinout`) of the 10:1 bus multiplexer and the register load enables (`rin`, `ain`, `gin`, `ir_in`). At most one bus source is active in any cycle.

## Interface
Parameters:
- `DW`, default 9: instruction and data width. Fixed at 9; the opcode is `ir[8:6]`, X is `ir[5:3]`, Y is `ir[2:0]`.

Ports:
- `clock`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `run`: input, 1 bit. Start request; sampled only in T0.
- `din`: input, DW bits. Instruction word; loaded into the IR when `ir_in`=1.
- `g_zero`: input, 1 bit. High when the G register is all zeros. Used only by `mvnz`.
- `ir`: output, DW bits. Current instruction register, for debug.
- `ir_in`: output, 1 bit. IR load strobe.
- `rout`: output, 8 bits. One-hot register select for the bus mux; bit n selects Rn.
- `gout`: output, 1 bit. Bus source is G.
- `dinout`: output, 1 bit. Bus source is DIN.
- `rin`: output, 8 bits. One-hot register load enables.
- `ain`: output, 1 bit. Load enable for the A register.
- `gin`: output, 1 bit. Load enable for the G register.
- `addsub`: output, 1 bit. ALU operation: 0 = add, 1 = subtract.
- `done`: output, 1 bit. One-cycle pulse in the final step of an instruction.

## Operation
- State register: T0, T1, T2, T3 (2-bit), plus a DW-bit IR.
- All outputs are combinational decodes of state, IR, `run` and `g_zero`. Every output not listed for a step is 0.
- T0 (fetch):
  - `ir_in` = `run`.
  - If `run`=1: load IR from `din` and go to T1. Otherwise stay in T0.
- Opcode 000, `mv Rx,Ry`:
  - T1: `rout`[Y]=1, `rin`[X]=1, `done`=1. Next state T0.
- Opcode 001, `mvi Rx,#D`:
  - T1: `dinout`=1, `rin`[X]=1, `done`=1. Next state T0.
  - The immediate is presented on `din` during T1.
- Opcode 010, `add Rx,Ry`:
  - T1: `rout`[X]=1, `ain`=1.
  - T2: `rout`[Y]=1, `gin`=1, `addsub`=0.
  - T3: `gout`=1, `rin`[X]=1, `done`=1. Next state T0.
- Opcode 011, `sub Rx,Ry`: same as `add`, but `addsub`=1 in T2.
- Opcode 100 (`mvnz`, configurable): see Configuration.
- Opcodes 101–111 are illegal. T1 asserts only `done`=1, then T0. No register is written.
- X=Y is legal. For example, `add R2,R2` doubles R2.
- `run` outside T0 is ignored. An instruction in progress is never aborted except by `reset`.
- Invariant in every cycle: popcount(`rout`) + `gout` + `dinout` ≤ 1. popcount(`rin`) ≤ 1.

## Timing
- Reset: state=T0, IR=0. With `run`=0, every output is 0, including `done` and `ir`.
- Reset mid-instruction: the next cycle is T0 with IR=0. No enables are asserted in the reset cycle or the cycle after, unless `run`=1 in that cycle.
- Latency from the `run` sample to `done`:
  - `mv`, `mvi`, `mvnz`, illegal: 1 cycle (2 cycles total).
  - `add`, `sub`: 3 cycles (4 cycles total).
- Back-to-back: with `run` held high, a new fetch occurs in the cycle after `done`. There is no idle bubble beyond T0.
- `addsub` is meaningful only in T2 and is 0 in all other states.

## Configuration
- Macro: `PROC_CTRL_MVNZ_EN`.
- Defined: opcode 100 is `mvnz Rx,Ry`.
  - T1: if `g_zero`=0, `rout`[Y]=1 and `rin`[X]=1. If `g_zero`=1, no selects or enables are asserted.
  - `done`=1 in T1 in both cases.
- Undefined: opcode 100 is illegal. It behaves like 101–111, and `g_zero` is unused.

## Test plan
- Reset, then `run`=1 with `din`=9'b001_011_000 (mvi R3). Next cycle is T1 with `dinout`=1, `rin`=8'h08, `done`=1, `rout`=0. The cycle after is T0.
- `din`=9'b010_001_010 (add R1,R2):
  - T1: `rout`=8'h02, `ain`=1.
  - T2: `rout`=8'h04, `gin`=1, `addsub`=0.
  - T3: `gout`=1, `rin`=8'h02, `done`=1.
- `din`=9'b011_000_111 (sub R0,R7): T2 has `rout`=8'h80 and `addsub`=1. T3 has `rin`=8'h01. Exactly one `done` pulse.
- `reset`=1 in T2 of an `add`. The next cycle shows T0, `ir`=0 and all enables 0. No `rin`/`gout` pulse from the aborted instruction occurs.
- Opcode 100 with `g_zero`=0 and then with `g_zero`=1, run with the macro defined and undefined:
  - Defined: `rin`/`rout` are asserted only when `g_zero`=0.
  - Undefined: only `done` is asserted.
  - `done`=1 in T1 in all four cases.
- Random instruction stream with `run` held high for 200 instructions. The one-hot bus-source invariant holds every cycle. The number of `done` pulses equals the number of `ir_in` pulses.
